if_stage: RTL and testbench

Instruction-fetch stage. Owns the PC, drives the program SRAM (Ram2) read interface and holds the IF/ID pipeline register that feeds id. Takes stall, flush and redirect controls from hazard, and predicts THCO-MIPS B/BEQZ/BNEZ branches so that IF/ID carries the fetched instruction, epc, pc+1 and the prediction bit.

---
 rtl/if_stage.sv | 147 ++++++++++++++
 tb/tb_if_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC, Ram2 read port, branch predecode and IF/ID register
// Optional IF_BHT_EN: 2-bit saturating branch-history table for BEQZ/BNEZ prediction.
module if_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INST  = 16'h0800,
  parameter int          BHT_IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        flush_if_i,
  input  logic        jump_i,
  input  logic [15:0] jump_addr_i,
  input  logic        br_update_i,
  input  logic [15:0] br_pc_i,
  input  logic        br_taken_i,
  output logic [17:0] Ram2Addr,
  inout  logic [15:0] Ram2Data,
  output logic        Ram2OE,
  output logic        Ram2WE,
  output logic        Ram2EN,
  output logic [15:0] inst_o,
  output logic [15:0] epc_o,
  output logic [15:0] pcplus1_o,
  output logic        pred_taken_o,
  output logic        valid_o
);

  typedef enum logic {BOOT = 1'b0, FETCH = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [15:0] pc, pc_nxt, pc_inc, br_off, fetch_word;
  logic        is_b, is_cond, cond_taken, pred_taken;

  // The SRAM is only ever read from this port.
  assign Ram2Data   = 16'hzzzz;
  assign Ram2WE     = 1'b1;
  assign Ram2Addr   = {2'b00, pc};
  assign fetch_word = Ram2Data;
  assign pc_inc     = pc + 16'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Ram2EN    = 1'b1;
    Ram2OE    = 1'b1;
    case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: begin
        Ram2EN = 1'b0;
        Ram2OE = 1'b0;
      end
    endcase
  end

  always_comb begin
    is_b    = 1'b0;
    is_cond = 1'b0;
    br_off  = 16'h0000;
    if (state == FETCH) begin
      case (fetch_word[15:11])
        5'b00010: begin
          is_b   = 1'b1;
          br_off = {{5{fetch_word[10]}}, fetch_word[10:0]};
        end
        5'b00100, 5'b00101: begin
          is_cond = 1'b1;
          br_off  = {{8{fetch_word[7]}}, fetch_word[7:0]};
        end
        default: ;
      endcase
    end
  end

`ifdef IF_BHT_EN
  localparam int BHT_N = 1 << BHT_IDX_W;

  logic [1:0]           bht [BHT_N];
  logic [BHT_IDX_W-1:0] upd_idx;
  logic                 unused_br_pc_hi;

  assign upd_idx         = br_pc_i[BHT_IDX_W-1:0];
  assign unused_br_pc_hi = ^br_pc_i[15:BHT_IDX_W];
  // Lookup reads the registered counter, so a same-cycle update is not yet visible.
  assign cond_taken      = bht[pc[BHT_IDX_W-1:0]][1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) bht[i] <= 2'b01;
    end else if (br_update_i) begin
      if (br_taken_i && bht[upd_idx] != 2'b11)
        bht[upd_idx] <= bht[upd_idx] + 2'd1;
      else if (!br_taken_i && bht[upd_idx] != 2'b00)
        bht[upd_idx] <= bht[upd_idx] - 2'd1;
    end
  end
`else
  localparam int unused_bht_idx_w = BHT_IDX_W;

  logic unused_br;

  assign unused_br  = ^{br_update_i, br_taken_i, br_pc_i};
  assign cond_taken = br_off[15];
`endif

  assign pred_taken = is_b | (is_cond & cond_taken);

  always_comb begin
    pc_nxt = pc;
    if (state == FETCH) begin
      if (jump_i)          pc_nxt = jump_addr_i;
      else if (hold_i)     pc_nxt = pc;
      else if (pred_taken) pc_nxt = pc_inc + br_off;
      else                 pc_nxt = pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_o       <= NOP_INST;
      epc_o        <= 16'h0000;
      pcplus1_o    <= 16'h0000;
      pred_taken_o <= 1'b0;
      valid_o      <= 1'b0;
    end else if (state == BOOT || flush_if_i || jump_i) begin
      inst_o       <= NOP_INST;
      pred_taken_o <= 1'b0;
      valid_o      <= 1'b0;
    end else if (!hold_i) begin
      inst_o       <= fetch_word;
      epc_o        <= pc;
      pcplus1_o    <= pc_inc;
      pred_taken_o <= pred_taken;
      valid_o      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage with an SRAM image and reference model
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hold_i = 1'b0, flush_if_i = 1'b0, jump_i = 1'b0;
  logic [15:0] jump_addr_i = 16'h0;
  logic        br_update_i = 1'b0, br_taken_i = 1'b0;
  logic [15:0] br_pc_i = 16'h0;
  logic [17:0] ram_addr;
  wire  [15:0] ram_data;
  logic        ram_oe, ram_we, ram_en;
  logic [15:0] inst_o, epc_o, pcplus1_o;
  logic        pred_taken_o, valid_o;

  logic [15:0] mem [0:65535];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;

  // Reference state
  logic        m_boot;
  logic [15:0] m_pc, m_inst, m_epc, m_pc1;
  logic        m_pred, m_valid;
  int          m_bht [16];

  always #5 clk = ~clk;

  assign ram_data = mem[ram_addr[15:0]];

  if_stage dut (
    .clk(clk), .rst(rst), .hold_i(hold_i), .flush_if_i(flush_if_i), .jump_i(jump_i),
    .jump_addr_i(jump_addr_i), .br_update_i(br_update_i), .br_pc_i(br_pc_i),
    .br_taken_i(br_taken_i), .Ram2Addr(ram_addr), .Ram2Data(ram_data), .Ram2OE(ram_oe),
    .Ram2WE(ram_we), .Ram2EN(ram_en), .inst_o(inst_o), .epc_o(epc_o),
    .pcplus1_o(pcplus1_o), .pred_taken_o(pred_taken_o), .valid_o(valid_o)
  );

  // Advance one clock, computing the model's next state from the rules first.
  task automatic tick();
    logic [15:0] w, n_pc, n_inst, n_epc, n_pc1;
    logic        n_pred, n_valid, n_boot;
    bit          tk;
    int          off, op;
    n_pc = m_pc; n_inst = m_inst; n_epc = m_epc; n_pc1 = m_pc1;
    n_pred = m_pred; n_valid = m_valid; n_boot = 1'b0;
    if (rst) begin
      n_boot = 1'b1; n_pc = 16'h0; n_inst = 16'h0800; n_epc = 16'h0; n_pc1 = 16'h0;
      n_pred = 1'b0; n_valid = 1'b0;
    end else if (m_boot) begin
      n_inst = 16'h0800; n_pred = 1'b0; n_valid = 1'b0;
    end else begin
      w = mem[m_pc]; op = int'(w[15:11]); tk = 1'b0; off = 0;
      if (op == 2) begin
        off = int'(w[10:0]); if (off >= 1024) off -= 2048; tk = 1'b1;
      end else if (op == 4 || op == 5) begin
        off = int'(w[7:0]); if (off >= 128) off -= 256;
`ifdef IF_BHT_EN
        tk = (m_bht[int'(m_pc) % 16] >= 2);
`else
        tk = (off < 0);
`endif
      end
      if (jump_i)      n_pc = jump_addr_i;
      else if (hold_i) n_pc = m_pc;
      else if (tk)     n_pc = m_pc + 16'd1 + 16'(off);
      else             n_pc = m_pc + 16'd1;
      if (flush_if_i || jump_i) begin
        n_inst = 16'h0800; n_pred = 1'b0; n_valid = 1'b0;
      end else if (!hold_i) begin
        n_inst = w; n_epc = m_pc; n_pc1 = m_pc + 16'd1; n_pred = tk; n_valid = 1'b1;
      end
    end
    if (rst) begin
      for (int i = 0; i < 16; i++) m_bht[i] = 1;
    end else if (br_update_i) begin
      if (br_taken_i) m_bht[int'(br_pc_i) % 16] = (m_bht[int'(br_pc_i) % 16] == 3) ? 3 : m_bht[int'(br_pc_i) % 16] + 1;
      else            m_bht[int'(br_pc_i) % 16] = (m_bht[int'(br_pc_i) % 16] == 0) ? 0 : m_bht[int'(br_pc_i) % 16] - 1;
    end
    @(posedge clk);
    #1;
    m_boot = n_boot; m_pc = n_pc; m_inst = n_inst; m_epc = n_epc; m_pc1 = n_pc1;
    m_pred = n_pred; m_valid = n_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    chk_cnt++; if (ram_en !== 1'b1) $display("FAIL rst_en got %b want 1", ram_en); else pass_cnt++;
    chk_cnt++; if (ram_oe !== 1'b1) $display("FAIL rst_oe got %b want 1", ram_oe); else pass_cnt++;
    chk_cnt++; if (ram_we !== 1'b1) $display("FAIL rst_we got %b want 1", ram_we); else pass_cnt++;
    chk_cnt++; if (inst_o !== 16'h0800) $display("FAIL rst_inst got %h want 0800", inst_o); else pass_cnt++;
    chk_cnt++; if (valid_o !== 1'b0) $display("FAIL rst_valid got %b want 0", valid_o); else pass_cnt++;
    chk_cnt++; if ({epc_o, pcplus1_o} !== 32'h0) $display("FAIL rst_epc got %h/%h want 0/0", epc_o, pcplus1_o); else pass_cnt++;
    chk_cnt++; if (pred_taken_o !== 1'b0) $display("FAIL rst_pred got %b want 0", pred_taken_o); else pass_cnt++;
    rst = 1'b0;
    chk_cnt++; if (ram_en !== 1'b1 || ram_addr !== 18'h0) $display("FAIL boot_en got en=%b addr=%h want en=1 addr=0", ram_en, ram_addr); else pass_cnt++;
    tick();
    chk_cnt++; if (ram_en !== 1'b0 || ram_oe !== 1'b0) $display("FAIL fetch_en got en=%b oe=%b want 0/0", ram_en, ram_oe); else pass_cnt++;
    chk_cnt++; if (ram_addr !== 18'h0 || inst_o !== 16'h0800 || valid_o !== 1'b0) $display("FAIL first_fetch got addr=%h inst=%h v=%b want 0/0800/0", ram_addr, inst_o, valid_o); else pass_cnt++;
  endtask

  task automatic test_sequential();
    logic [15:0] exp_inst [3];
    exp_inst[0] = 16'h6801; exp_inst[1] = 16'h6902; exp_inst[2] = 16'h0800;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_cnt++; if (ram_addr !== 18'(i + 1)) $display("FAIL seq_addr%0d got %h want %h", i, ram_addr, 18'(i + 1)); else pass_cnt++;
      chk_cnt++; if (inst_o !== exp_inst[i] || valid_o !== 1'b1) $display("FAIL seq_inst%0d got %h v=%b want %h v=1", i, inst_o, valid_o, exp_inst[i]); else pass_cnt++;
      chk_cnt++; if (epc_o !== 16'(i) || pcplus1_o !== 16'(i + 1)) $display("FAIL seq_epc%0d got %h/%h want %h/%h", i, epc_o, pcplus1_o, 16'(i), 16'(i + 1)); else pass_cnt++;
    end
  endtask

  task automatic test_branch();
    logic [17:0] exp_addr;
    logic        exp_pred;
`ifdef IF_BHT_EN
    exp_addr = 18'h6; exp_pred = 1'b0;
`else
    exp_addr = 18'h4; exp_pred = 1'b1;
`endif
    jump_i = 1'b1; jump_addr_i = 16'h0005; tick(); jump_i = 1'b0;
    tick();
    chk_cnt++; if (ram_addr !== exp_addr) $display("FAIL bwd_addr got %h want %h", ram_addr, exp_addr); else pass_cnt++;
    chk_cnt++; if (inst_o !== 16'h20FE || pred_taken_o !== exp_pred) $display("FAIL bwd_pred got %h/%b want 20fe/%b", inst_o, pred_taken_o, exp_pred); else pass_cnt++;
    jump_i = 1'b1; jump_addr_i = 16'h0008; tick(); jump_i = 1'b0;
    tick();
    chk_cnt++; if (ram_addr !== 18'h9) $display("FAIL fwd_addr got %h want 9", ram_addr); else pass_cnt++;
    chk_cnt++; if (inst_o !== 16'h2803 || pred_taken_o !== 1'b0) $display("FAIL fwd_pred got %h/%b want 2803/0", inst_o, pred_taken_o); else pass_cnt++;
  endtask

  task automatic test_stall_redirect();
    jump_i = 1'b1; jump_addr_i = 16'h0009; tick(); jump_i = 1'b0;
    tick();
    hold_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_cnt++; if (ram_addr !== 18'hA) $display("FAIL hold_addr%0d got %h want a", i, ram_addr); else pass_cnt++;
      chk_cnt++; if (inst_o !== 16'h6909 || epc_o !== 16'h9 || pcplus1_o !== 16'hA || valid_o !== 1'b1)
        $display("FAIL hold_ifid%0d got %h/%h/%h/%b want 6909/0009/000a/1", i, inst_o, epc_o, pcplus1_o, valid_o); else pass_cnt++;
    end
    jump_i = 1'b1; jump_addr_i = 16'h0040;
    tick();
    jump_i = 1'b0; hold_i = 1'b0;
    chk_cnt++; if (ram_addr !== 18'h40) $display("FAIL jump_hold_addr got %h want 40", ram_addr); else pass_cnt++;
    chk_cnt++; if (inst_o !== 16'h0800 || valid_o !== 1'b0 || pred_taken_o !== 1'b0) $display("FAIL jump_hold_ifid got %h/%b/%b want 0800/0/0", inst_o, valid_o, pred_taken_o); else pass_cnt++;
  endtask

  task automatic test_wrap_flush();
    jump_i = 1'b1; jump_addr_i = 16'hFFFF; tick(); jump_i = 1'b0;
    tick();
    chk_cnt++; if (ram_addr !== 18'h0) $display("FAIL wrap_addr got %h want 0", ram_addr); else pass_cnt++;
    chk_cnt++; if (inst_o !== 16'h6B01 || epc_o !== 16'hFFFF || pcplus1_o !== 16'h0000) $display("FAIL wrap_ifid got %h/%h/%h want 6b01/ffff/0000", inst_o, epc_o, pcplus1_o); else pass_cnt++;
    jump_i = 1'b1; jump_addr_i = 16'd20; tick(); jump_i = 1'b0;
    flush_if_i = 1'b1;
    tick();
    flush_if_i = 1'b0;
    chk_cnt++; if (ram_addr !== 18'd21) $display("FAIL flush_addr got %h want 15", ram_addr); else pass_cnt++;
    chk_cnt++; if (inst_o !== 16'h0800 || valid_o !== 1'b0) $display("FAIL flush_ifid got %h/%b want 0800/0", inst_o, valid_o); else pass_cnt++;
  endtask

`ifdef IF_BHT_EN
  task automatic test_bht();
    br_update_i = 1'b1; br_pc_i = 16'h0013; br_taken_i = 1'b1;
    tick(); tick();
    br_update_i = 1'b0;
    jump_i = 1'b1; jump_addr_i = 16'h0003; tick(); jump_i = 1'b0;
    tick();
    chk_cnt++; if (ram_addr !== 18'h8 || pred_taken_o !== 1'b1) $display("FAIL bht_taken got addr=%h p=%b want 8/1", ram_addr, pred_taken_o); else pass_cnt++;
    br_update_i = 1'b1; br_taken_i = 1'b0;
    tick(); tick();
    br_update_i = 1'b0;
    jump_i = 1'b1; jump_addr_i = 16'h0003; tick(); jump_i = 1'b0;
    tick();
    chk_cnt++; if (ram_addr !== 18'h4 || pred_taken_o !== 1'b0) $display("FAIL bht_not_taken got addr=%h p=%b want 4/0", ram_addr, pred_taken_o); else pass_cnt++;
  endtask
`endif

  task automatic test_random();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      hold_i      = ($urandom % 5) == 0;
      flush_if_i  = ($urandom % 10) == 0;
      jump_i      = ($urandom % 12) == 0;
      jump_addr_i = 16'($urandom);
      br_update_i = ($urandom % 3) == 0;
      br_pc_i     = 16'($urandom);
      br_taken_i  = 1'($urandom);
      tick();
      chk_cnt++; if (ram_addr !== {2'b00, m_pc}) $display("FAIL rnd_addr c%0d got %h want %h", c, ram_addr, {2'b00, m_pc}); else pass_cnt++;
      chk_cnt++; if (ram_en !== m_boot || ram_oe !== m_boot) $display("FAIL rnd_en c%0d got %b/%b want %b", c, ram_en, ram_oe, m_boot); else pass_cnt++;
      chk_cnt++; if (inst_o !== m_inst || valid_o !== m_valid) $display("FAIL rnd_inst c%0d got %h/%b want %h/%b", c, inst_o, valid_o, m_inst, m_valid); else pass_cnt++;
      chk_cnt++; if (epc_o !== m_epc || pcplus1_o !== m_pc1) $display("FAIL rnd_epc c%0d got %h/%h want %h/%h", c, epc_o, pcplus1_o, m_epc, m_pc1); else pass_cnt++;
      chk_cnt++; if (pred_taken_o !== m_pred) $display("FAIL rnd_pred c%0d got %b want %b", c, pred_taken_o, m_pred); else pass_cnt++;
    end
    hold_i = 1'b0; flush_if_i = 1'b0; jump_i = 1'b0; br_update_i = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    int          r;
    for (int i = 0; i < 65536; i++) begin
      r = int'($urandom);
      w = 16'($urandom);
      if (r % 4 == 0)      w[15:11] = 5'b00010;
      else if (r % 4 == 1) w[15:11] = (r[4]) ? 5'b00101 : 5'b00100;
      mem[i] = w;
    end
    mem[0] = 16'h6801; mem[1] = 16'h6902; mem[2] = 16'h0800; mem[3] = 16'h2804;
    mem[4] = 16'h0800; mem[5] = 16'h20FE; mem[6] = 16'h0800; mem[7] = 16'h0800;
    mem[8] = 16'h2803; mem[9] = 16'h6909; mem[10] = 16'h6A0A; mem[20] = 16'h6C14;
    mem[16'hFFFF] = 16'h6B01;

    test_reset();
    test_sequential();
    test_branch();
    test_stall_redirect();
    test_wrap_flush();
`ifdef IF_BHT_EN
    test_bht();
`endif
    test_random();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
